mem_access_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the processor's instruction-fetch and data

---
 rtl/mem_access_arbiter_pkg.sv | 19 +
 rtl/arb_winner_sel.sv | 32 +++
 rtl/mem_access_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_access_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, owner codes, default widths.
package mem_access_arbiter_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int MEM_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_winner_sel.sv
// Picks which requester owns the next memory access.
// ARB_ROUND_ROBIN_EN selects alternating grants on conflict; default is data-first.
module arb_winner_sel
    import mem_access_arbiter_pkg::*;
(
    input  logic   ireq,
    input  logic   dreq,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e grant_owner
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_valid = ireq | dreq;
        grant_owner = OWN_I;
        if (ireq && dreq)
            grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        else if (dreq)
            grant_owner = OWN_D;
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        grant_valid = ireq | dreq;
        grant_owner = dreq ? OWN_D : OWN_I;
    end
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// Serialises fetch and data requests onto one fixed-latency synchronous RAM.
// Conflict policy set by ARB_ROUND_ROBIN_EN (see arb_winner_sel).
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ireq,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dwdata,
    output logic              iacq,
    output logic              dacq,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic              iacq_q, iacq_d;
    logic              dacq_q, dacq_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic   grant_valid;
    owner_e grant_owner;

    arb_winner_sel u_sel (
        .ireq        (ireq),
        .dreq        (dreq),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        iacq_d       = 1'b0;
        dacq_d       = 1'b0;
        busy_d       = busy_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (grant_valid) begin
                    state_d      = ST_ACCESS;
                    cnt_d        = '0;
                    owner_d      = grant_owner;
                    last_owner_d = grant_owner;
                    busy_d       = 1'b1;
                    mem_en_d     = 1'b1;
                    if (grant_owner == OWN_D) begin
                        mem_addr_d  = daddr;
                        mem_we_d    = dwe;
                        mem_wdata_d = dwdata;
                    end else begin
                        mem_addr_d  = iaddr;
                        mem_we_d    = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (!mem_we_q)
                        rdata_d = mem_rdata;
                    state_d = ST_ACK;
                    cnt_d   = '0;
                    iacq_d  = (owner_q == OWN_I);
                    dacq_d  = (owner_q == OWN_D);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACK: begin
                // Always pass through IDLE so a held request cannot re-grant here
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            iacq_q       <= 1'b0;
            dacq_q       <= 1'b0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            iacq_q       <= iacq_d;
            dacq_q       <= dacq_d;
            busy_q       <= busy_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign iacq      = iacq_q;
    assign dacq      = dacq_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter with a simple RAM model.
module tb_mem_access_arbiter;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ireq, dreq, dwe;
    logic [7:0] iaddr, daddr, dwdata;
    logic       iacq, dacq, busy, mem_en, mem_we;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    mem_access_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .ireq(ireq), .iaddr(iaddr),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .iacq(iacq), .dacq(dacq), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_d;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic       is_d;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    // RAM model: one edge to latch the read, data held until the next read
    logic [7:0] mem [256];

    function automatic logic [7:0] pre(int a);
        case (a)
            'h10:    return 8'hA5;
            'h21:    return 8'h5A;
            'hFF:    return 8'h81;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= pre(i);
            mem_rdata <= 8'h00;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    int en_cnt = 0;
    int acq_cnt = 0;
    int both_hi = 0;
    logic [7:0] cap_addr, cap_wdata;
    logic       cap_we;

    always @(posedge clk) begin
        if (mem_en) begin
            en_cnt++;
            cap_addr  = mem_addr;
            cap_we    = mem_we;
            cap_wdata = mem_wdata;
        end
        if (iacq || dacq) acq_cnt++;
        if (iacq && dacq) both_hi++;
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acq(output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            cyc++;
            if (iacq || dacq) ok = 1'b1;
        end
        chk("acq_timeout", int'(ok), 1);
    endtask

    task automatic score(string tag, int cyc, int exp_cyc);
        exp_t e;
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_sb_nonempty"}, int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_iacq"}, int'(iacq), int'(!e.is_d));
            chk({tag, "_dacq"}, int'(dacq), int'(e.is_d));
            chk({tag, "_rdata"}, int'(rdata), int'(e.rdata));
            chk({tag, "_mem_addr"}, int'(cap_addr), int'(e.addr));
            chk({tag, "_mem_we"}, int'(cap_we), int'(e.we));
            if (e.we) chk({tag, "_mem_wdata"}, int'(cap_wdata), int'(e.wdata));
        end
    endtask

    function automatic exp_t mk(logic d, logic w, logic [7:0] a, logic [7:0] wd, logic [7:0] r);
        exp_t e;
        e.is_d = d; e.we = w; e.addr = a; e.wdata = wd; e.rdata = r;
        return e;
    endfunction

    vec_t vecs[7];

    initial begin
        int cyc, e0, a0;
        logic exp_d;

        vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'hA5};
        vecs[2] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h3C};
        vecs[3] = '{1'b0, 1'b0, 8'h21, 8'h00, 8'h5A};
        vecs[4] = '{1'b1, 1'b1, 8'h10, 8'hF0, 8'h5A};
        vecs[5] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hF0};
        vecs[6] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h81};

        rst = 1'b1; ireq = 1'b1; dreq = 1'b1; dwe = 1'b1;
        iaddr = 8'h10; daddr = 8'h20; dwdata = 8'h3C;

        // Reset held with both requests asserted
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_ctrl", int'({iacq, dacq, busy, mem_en, mem_we}), 0);
            chk("rst_data", int'({rdata, mem_addr, mem_wdata}), 0);
        end
        chk("rst_no_mem_en", en_cnt, 0);
        rst = 1'b0; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
        tick();
        chk("idle_busy", int'(busy), 0);

        // Continuous conflict straight after reset
        ireq = 1'b1; iaddr = 8'h10;
        dreq = 1'b1; daddr = 8'h21; dwe = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            sbq.push_back(exp_d ? mk(1'b1, 1'b0, 8'h21, 8'h00, 8'h5A)
                                : mk(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5));
            wait_acq(cyc);
            score("conflict", cyc, (k == 0) ? LAT + 1 : LAT + 2);
        end
        ireq = 1'b0; dreq = 1'b0;
        tick();

        // Reset in the second ACCESS cycle aborts the access
        ireq = 1'b1; iaddr = 8'h21;
        tick();
        chk("abort_mem_en", int'(mem_en), 1);
        tick();
        chk("abort_busy_pre", int'(busy), 1);
        a0 = acq_cnt;
        rst = 1'b1; ireq = 1'b0;
        tick();
        chk("abort_busy_post", int'(busy), 0);
        chk("abort_acq", int'({iacq, dacq}), 0);
        rst = 1'b0;
        repeat (4) tick();
        chk("abort_no_acq", acq_cnt - a0, 0);

        // Table-driven single transactions
        foreach (vecs[i]) begin
            ireq = !vecs[i].is_d;
            dreq = vecs[i].is_d;
            dwe = vecs[i].we;
            iaddr = vecs[i].addr;
            daddr = vecs[i].addr;
            dwdata = vecs[i].wdata;
            sbq.push_back(mk(vecs[i].is_d, vecs[i].we, vecs[i].addr,
                             vecs[i].wdata, vecs[i].exp_rdata));
            e0 = en_cnt;
            wait_acq(cyc);
            score("vec", cyc, LAT + 1);
            chk("vec_one_mem_en", en_cnt - e0, 1);
            chk("vec_ack_busy", int'(busy), 1);
            ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
            tick();
            chk("vec_idle", int'({busy, iacq, dacq}), 0);
        end

        // Request fields change and ireq drops during ACCESS
        ireq = 1'b1; iaddr = 8'h21;
        sbq.push_back(mk(1'b0, 1'b0, 8'h21, 8'h00, 8'h5A));
        a0 = acq_cnt;
        tick();
        iaddr = 8'h99; ireq = 1'b0;
        wait_acq(cyc);
        chk("hold_mem_addr", int'(mem_addr), 'h21);
        score("hold", cyc, LAT);
        repeat (5) tick();
        chk("hold_single_acq", acq_cnt - a0, 1);

        chk("acq_exclusive", both_hi, 0);
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
